main_mod: RTL and testbench
===========================

# main_mod

Trace-driven model of a YACC-style (Yet Another Compressed Cache) set-associative cache with true-LRU replacement. It takes one 32-bit address per clock, classifies it as a hit or miss, updates tag, sub-block and LRU state, and reports per-access results and running hit/miss counts. It is the top-level block of the cache-compression study and carries no data path; only tags and occupancy are modelled.

## Interface
- No parameters. Fixed geometry: 8 sets, 4 ways, 4 sub-blocks per superblock, 64-byte blocks.
- clock  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous, active-low reset
- address  input  32  access address; fields [31:11] tag (21b), [10:8] set, [7:6] sub-block index, [5:0] byte offset (ignored)
- hit  output  1  registered: previous access hit
- miss  output  1  registered: previous access missed
- evict  output  1  registered: previous miss displaced a valid way
- hit_way  output  2  registered: way hit or filled by the previous access
- hit_count  output  32  total hits since reset
- miss_count  output  32  total misses since reset

## Operation
- Every rising edge with resetn high is one access, including repeats of the same address. There is no valid/enable input.
- Per-way state: valid, tag[20:0], compressed flag, 4-bit sub-block mask, 2-bit LRU age.
- Compressibility is fixed by rule: a superblock is compressible iff tag[0]==0. A compressible superblock stores all of its present sub-blocks in a single way, with any subset of mask bits set. A non-compressible block occupies a whole way, with exactly one mask bit set.
- Lookup in set S with tag T and sub-block index B:
  - hit: a valid way with tag==T, compressed flag matching compressibility(T), and mask[B]==1.
  - compressible partial miss: a valid compressed way with tag==T exists but mask[B]==0. Set mask[B]. No eviction. Counts as a miss. That way becomes MRU.
  - full miss: allocate the lowest-index invalid way. If none is invalid, allocate the way with age 3 (LRU) and assert evict. Write valid=1, tag=T, compressed=compressibility(T), mask=one-hot B.
- At most one way may match a given (T,B). Non-compressible (T,B) pairs each get their own way.
- LRU update on every access, for the accessed or filled way w: each way with age < age[w] increments; age[w] becomes 0. Ages stay a permutation of 0..3.
- Counters wrap modulo 2^32. Exactly one of hit/miss is high in each cycle after the first post-reset access.

## Timing
- Reset (async assert, sync release): all ways invalid, masks 0, ages equal the way index (way0=0 … way3=3), hit=miss=evict=0, hit_way=0, counters 0.
- Latency is 1 cycle. Outputs reflect the address sampled at the previous rising edge. Counters include that access in the same cycle the flags show it.
- Back-to-back accesses to the same set are allowed every cycle. Each lookup sees all state written by the previous edge.
- resetn asserted mid-trace clears everything immediately. The access at the edge during reset is discarded.

## Test plan
- Reset then set 0, tag 0 (compressible), sub-blocks 1,2,3 -> miss, miss, miss. All land in way 0, mask=1110, no evict. Re-access sub-block 1 -> hit, hit_way=0.
- Set 0, tag 1 (non-compressible), sub-blocks 0,1,3,2 after the above -> 4 misses filling ways 1,2,3, then the fourth evicts way 0 (tag 0, the LRU way). evict=1 on that access only.
- Same address issued on 3 consecutive cycles (tag 2, set 1, sub-block 1) -> miss, hit, hit. hit_count increases by 2 and miss_count by 1.
- Set 0, tag 3 (non-compressible) sub-block 1 twice, then tag 4 sub-block 0 -> miss, hit, miss. LRU victims follow the age order and ages remain a permutation.
- Full repeated trace: 29 accesses mixing sets 0/1 and tags 0-4 -> final hit_count + miss_count = 29. Counts match a software LRU reference model using the same compressibility rule.
- resetn pulsed low mid-trace -> outputs and counters drop to 0 immediately. The next access to a previously resident address misses.

Source files
------------

// File: rtl/main_mod_if.sv
// ---------------------------------------------------------------------------
// main_mod_if
//
// Access/result bundle for the compressed-cache trace model.
//   address    : 32-bit access address, one access per clock
//   hit        : previous access hit
//   miss       : previous access missed (full or partial)
//   evict      : previous miss displaced a valid way
//   hit_way    : way hit or filled by the previous access
//   hit_count  : running hit total since reset
//   miss_count : running miss total since reset
//
// master drives the address and observes results; slave is the cache model.
// ---------------------------------------------------------------------------
interface main_mod_if;
    logic [31:0] address;
    logic        hit;
    logic        miss;
    logic        evict;
    logic [1:0]  hit_way;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport master (
        output address,
        input  hit,
        input  miss,
        input  evict,
        input  hit_way,
        input  hit_count,
        input  miss_count
    );

    modport slave (
        input  address,
        output hit,
        output miss,
        output evict,
        output hit_way,
        output hit_count,
        output miss_count
    );
endinterface

// File: rtl/main_mod.sv
// ---------------------------------------------------------------------------
// main_mod
//
// Tag/occupancy model of a YACC-style compressed, set-associative cache
// (8 sets x 4 ways, 4 sub-blocks per superblock, 64-byte blocks) with true-LRU
// replacement. One address is consumed on every rising clock edge; the result
// of that access is presented on the registered outputs one cycle later.
//
// Ports:
//   clock  : system clock, all state changes on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : main_mod_if.slave
//            address[31:11] tag, [10:8] set, [7:6] sub-block, [5:0] ignored
//            hit / miss / evict / hit_way  registered per-access result
//            hit_count / miss_count        running totals, wrap at 2^32
//
// A superblock is compressible when tag[0] == 0. Compressible superblocks
// keep every present sub-block in one way (mask may hold several bits);
// non-compressible ones use a whole way per sub-block (one-hot mask).
// ---------------------------------------------------------------------------
module main_mod (
    input  logic      clock,
    input  logic      resetn,
    main_mod_if.slave bus
);

    localparam int NUM_SETS   = 8;
    localparam int NUM_WAYS   = 4;
    localparam int TAG_W      = 21;
    localparam int SUB_BLOCKS = 4;

    typedef enum logic [1:0] {
        ACC_HIT,      // tag, compression and sub-block all present
        ACC_PARTIAL,  // compressed superblock resident, sub-block absent
        ACC_FILL      // nothing usable resident: allocate a way
    } acc_kind_t;

    // -----------------------------------------------------------------------
    // Cache state. Every way of the addressed set is compared in the same
    // cycle and the set is rewritten on the following edge, so the state is
    // held in flops rather than a RAM.
    // -----------------------------------------------------------------------
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   comp_q  [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [SUB_BLOCKS-1:0] mask_q  [NUM_SETS][NUM_WAYS];
    logic [1:0]            age_q   [NUM_SETS][NUM_WAYS];

    // Registered results
    logic        hit_q;
    logic        miss_q;
    logic        evict_q;
    logic [1:0]  hit_way_q;
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [TAG_W-1:0] tag_in;
    logic [2:0]       set_in;
    logic [1:0]       sb_in;
    logic             compressible_in;
    logic             offset_unused;

    assign tag_in          = bus.address[31:11];
    assign set_in          = bus.address[10:8];
    assign sb_in           = bus.address[7:6];
    assign compressible_in = ~tag_in[0];
    // Byte offset has no effect on a tag-only model.
    assign offset_unused   = ^bus.address[5:0];

    // -----------------------------------------------------------------------
    // View of the addressed set and per-way match terms
    // -----------------------------------------------------------------------
    logic [NUM_WAYS-1:0]   row_valid;
    logic [NUM_WAYS-1:0]   row_comp;
    logic [TAG_W-1:0]      row_tag  [NUM_WAYS];
    logic [SUB_BLOCKS-1:0] row_mask [NUM_WAYS];
    logic [1:0]            row_age  [NUM_WAYS];

    logic [NUM_WAYS-1:0]   tag_match;
    logic [NUM_WAYS-1:0]   way_hit;
    logic [NUM_WAYS-1:0]   way_partial;
    logic [NUM_WAYS-1:0]   way_lru;

    assign row_valid = valid_q[set_in];
    assign row_comp  = comp_q[set_in];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way_match
            assign row_tag[gi]  = tag_q[set_in][gi];
            assign row_mask[gi] = mask_q[set_in][gi];
            assign row_age[gi]  = age_q[set_in][gi];

            assign tag_match[gi]   = row_valid[gi] && (row_tag[gi] == tag_in);
            // The compressed flag must agree with the tag's compressibility;
            // for a non-compressible way the one-hot mask selects the block.
            assign way_hit[gi]     = tag_match[gi]
                                  && (row_comp[gi] == compressible_in)
                                  && row_mask[gi][sb_in];
            // Only a compressed superblock can absorb a new sub-block.
            assign way_partial[gi] = tag_match[gi] && row_comp[gi]
                                  && compressible_in && !row_mask[gi][sb_in];
            // Ages are a permutation of 0..3, so exactly one way is age 3.
            assign way_lru[gi]     = (row_age[gi] == 2'd3);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Access classification and way selection
    // -----------------------------------------------------------------------
    logic [1:0]            hit_idx;
    logic [1:0]            partial_idx;
    logic [1:0]            free_idx;
    logic [1:0]            lru_idx;
    logic [1:0]            acc_way;
    logic [1:0]            acc_age;
    acc_kind_t             acc_kind_d;
    logic [SUB_BLOCKS-1:0] sb_onehot;

    logic        hit_d;
    logic        miss_d;
    logic        evict_d;
    logic [31:0] hit_count_d;
    logic [31:0] miss_count_d;

    always_comb begin
        hit_idx     = '0;
        partial_idx = '0;
        free_idx    = '0;
        lru_idx     = '0;
        // Descending scans leave the lowest matching index selected.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_idx = 2'(w);
            end
            if (way_partial[w]) begin
                partial_idx = 2'(w);
            end
            if (!row_valid[w]) begin
                free_idx = 2'(w);
            end
            if (way_lru[w]) begin
                lru_idx = 2'(w);
            end
        end
    end

    always_comb begin
        acc_kind_d = ACC_FILL;
        acc_way    = lru_idx;
        evict_d    = 1'b0;
        if (|way_hit) begin
            acc_kind_d = ACC_HIT;
            acc_way    = hit_idx;
        end else if (|way_partial) begin
            acc_kind_d = ACC_PARTIAL;
            acc_way    = partial_idx;
        end else if (!(&row_valid)) begin
            acc_kind_d = ACC_FILL;
            acc_way    = free_idx;
        end else begin
            acc_kind_d = ACC_FILL;
            acc_way    = lru_idx;
            evict_d    = 1'b1;
        end
    end

    assign acc_age   = row_age[acc_way];
    assign sb_onehot = SUB_BLOCKS'(1) << sb_in;

    assign hit_d        = (acc_kind_d == ACC_HIT);
    assign miss_d       = !hit_d;
    assign hit_count_d  = hit_count_q  + {31'd0, hit_d};
    assign miss_count_d = miss_count_q + {31'd0, miss_d};

    // -----------------------------------------------------------------------
    // True-LRU ages: the touched way becomes 0 and every way that was younger
    // than it ages by one, which keeps the set's ages a permutation.
    // -----------------------------------------------------------------------
    logic [1:0] age_d [NUM_WAYS];

    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_age_next
            always_comb begin
                age_d[gi] = row_age[gi];
                if (2'(gi) == acc_way) begin
                    age_d[gi] = 2'd0;
                end else if (row_age[gi] < acc_age) begin
                    age_d[gi] = row_age[gi] + 2'd1;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State update
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                comp_q[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    mask_q[s][w] <= '0;
                    age_q[s][w]  <= 2'(w);
                end
            end
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                age_q[set_in][w] <= age_d[w];
            end
            case (acc_kind_d)
                ACC_PARTIAL: begin
                    mask_q[set_in][acc_way] <= row_mask[acc_way] | sb_onehot;
                end
                ACC_FILL: begin
                    valid_q[set_in][acc_way] <= 1'b1;
                    comp_q[set_in][acc_way]  <= compressible_in;
                    tag_q[set_in][acc_way]   <= tag_in;
                    mask_q[set_in][acc_way]  <= sb_onehot;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            evict_q      <= 1'b0;
            hit_way_q    <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            evict_q      <= evict_d;
            hit_way_q    <= acc_way;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.evict      = evict_q;
    assign bus.hit_way    = hit_way_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_main_mod.sv
// ---------------------------------------------------------------------------
// tb_main_mod
//
// Scoreboard bench for main_mod. The stimulus process drives one address per
// clock and pushes the expected result; a monitor pops and compares whenever
// the DUT shows hit or miss. Directed vectors carry hand-computed results; the
// long mixed trace takes its expectations from a recency-list LRU model.
// ---------------------------------------------------------------------------
module tb_main_mod;

    logic clock = 1'b0;
    logic resetn;

    main_mod_if bus ();

    main_mod dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        hit;
        logic        miss;
        logic        evict;
        logic [1:0]  way;
        logic [31:0] hc;
        logic [31:0] mc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;
    int   exp_hc = 0;
    int   exp_mc = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] mk_addr(int tag, int set, int sub);
        // Non-zero byte offset: it must not influence the result.
        return {21'(tag), 3'(set), 2'(sub), 6'h15};
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (resetn === 1'b1 && (bus.hit || bus.miss)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output hit=%0b miss=%0b required=none",
                         bus.hit, bus.miss);
            end else begin
                mon_x = sb_q.pop_front();
                check({mon_x.name, "/hit_miss_evict_way"},
                      64'({bus.hit, bus.miss, bus.evict, bus.hit_way}),
                      64'({mon_x.hit, mon_x.miss, mon_x.evict, mon_x.way}));
                check({mon_x.name, "/counts"},
                      {bus.hit_count, bus.miss_count}, {mon_x.hc, mon_x.mc});
                $display("access %-12s hit=%0b miss=%0b evict=%0b way=%0d hc=%0d mc=%0d",
                         mon_x.name, bus.hit, bus.miss, bus.evict, bus.hit_way,
                         bus.hit_count, bus.miss_count);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic issue(input logic [31:0] a, input logic h, input logic e,
                         input int w, input string name);
        exp_t x;
        @(negedge clock);
        #2;
        bus.address = a;
        resetn      = 1'b1;
        if (h) exp_hc++;
        else   exp_mc++;
        x.hit   = h;
        x.miss  = !h;
        x.evict = e;
        x.way   = 2'(w);
        x.hc    = 32'(exp_hc);
        x.mc    = 32'(exp_mc);
        x.name  = name;
        sb_q.push_back(x);
    endtask

    // Returns at negedge+1 once the last issued access has been checked.
    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/hit"},        64'(bus.hit),        64'd0);
        check({tag, "/miss"},       64'(bus.miss),       64'd0);
        check({tag, "/evict"},      64'(bus.evict),      64'd0);
        check({tag, "/hit_way"},    64'(bus.hit_way),    64'd0);
        check({tag, "/hit_count"},  64'(bus.hit_count),  64'd0);
        check({tag, "/miss_count"}, 64'(bus.miss_count), 64'd0);
    endtask

    // Called right after drain: asserts reset before the next rising edge.
    task automatic do_reset(input string tag);
        #1;
        resetn = 1'b0;
        #1;
        check_zero(tag);
        exp_hc = 0;
        exp_mc = 0;
        repeat (2) @(negedge clock);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-set recency list, index 0 = most recent.
    // ------------------------------------------------------------------
    logic        m_valid [8][4];
    logic [20:0] m_tag   [8][4];
    logic        m_comp  [8][4];
    logic [3:0]  m_mask  [8][4];
    int          m_order [8][4];

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[s][i] = 1'b0;
                m_tag[s][i]   = '0;
                m_comp[s][i]  = 1'b0;
                m_mask[s][i]  = '0;
                m_order[s][i] = i;
            end
        end
    endtask

    task automatic model_access(input logic [31:0] a, output logic h,
                                output logic e, output int w);
        int          s;
        int          b;
        int          p;
        logic [20:0] t;
        logic        ct;
        s  = int'(a[10:8]);
        b  = int'(a[7:6]);
        t  = a[31:11];
        ct = (t[0] == 1'b0);
        h  = 1'b0;
        e  = 1'b0;
        w  = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && m_valid[s][k] && m_tag[s][k] == t && m_comp[s][k] == ct
                && m_mask[s][k][b]) begin
                h = 1'b1;
                w = k;
            end
        end
        if (w < 0 && ct) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && m_valid[s][k] && m_comp[s][k] && m_tag[s][k] == t) begin
                    m_mask[s][k][b] = 1'b1;
                    w = k;
                end
            end
        end
        if (w < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && !m_valid[s][k]) w = k;
            end
            if (w < 0) begin
                w = m_order[s][3];
                e = 1'b1;
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            m_comp[s][w]  = ct;
            m_mask[s][w]  = 4'b0001 << b;
        end
        p = 0;
        for (int k = 0; k < 4; k++) begin
            if (m_order[s][k] == w) p = k;
        end
        for (int k = p; k > 0; k--) m_order[s][k] = m_order[s][k-1];
        m_order[s][0] = w;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [31:0] last_addr;

    initial begin
        logic h;
        logic e;
        int   w;
        logic [31:0] a;

        bus.address = '0;
        resetn = 1'b1;
        #1;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_zero("reset");

        // Compressible superblock fills one way sub-block by sub-block.
        issue(mk_addr(0, 0, 1), 0, 0, 0, "A_t0_sb1");
        issue(mk_addr(0, 0, 2), 0, 0, 0, "A_t0_sb2");
        issue(mk_addr(0, 0, 3), 0, 0, 0, "A_t0_sb3");
        issue(mk_addr(0, 0, 1), 1, 0, 0, "A_t0_sb1_re");
        // Non-compressible tag: one way per sub-block, 4th evicts way 0.
        issue(mk_addr(1, 0, 0), 0, 0, 1, "B_t1_sb0");
        issue(mk_addr(1, 0, 1), 0, 0, 2, "B_t1_sb1");
        issue(mk_addr(1, 0, 3), 0, 0, 3, "B_t1_sb3");
        issue(mk_addr(1, 0, 2), 0, 1, 0, "B_t1_sb2");
        // Same address three cycles in a row.
        issue(mk_addr(2, 1, 1), 0, 0, 0, "C_rep0");
        issue(mk_addr(2, 1, 1), 1, 0, 0, "C_rep1");
        issue(mk_addr(2, 1, 1), 1, 0, 0, "C_rep2");
        // Set 0 ages now {0,3,2,1}: victims way1 then way2.
        issue(mk_addr(3, 0, 1), 0, 1, 1, "D_t3_sb1");
        issue(mk_addr(3, 0, 1), 1, 0, 1, "D_t3_sb1_re");
        issue(mk_addr(4, 0, 0), 0, 1, 2, "D_t4_sb0");
        drain();
        check("directed_hit_count",  64'(bus.hit_count),  64'd4);
        check("directed_miss_count", 64'(bus.miss_count), 64'd10);
        do_reset("reset_after_directed");

        // Mixed 29-access trace against the reference model.
        model_reset();
        for (int i = 0; i < 29; i++) begin
            a = mk_addr((i * 3 + i / 4) % 5, (i / 3) % 2, (i + i / 5) % 4);
            model_access(a, h, e, w);
            issue(a, h, e, w, $sformatf("trace%0d", i));
            last_addr = a;
        end
        drain();
        check("trace_total", 64'(bus.hit_count + bus.miss_count), 64'd29);

        // Reset mid-trace: resident address must miss afterwards.
        do_reset("reset_mid_trace");
        issue(last_addr, 0, 0, 0, "post_reset_miss");
        issue(last_addr, 1, 0, 0, "post_reset_hit");
        drain();
        do_reset("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
